// File: rtl/key_conditioner_if.sv
// Key bundle between raw push-buttons and the conditioned event outputs.
// The conditioner takes the slave view; the stimulus/consumer side takes the master view.
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] i_key_n;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_hold;

  modport master (
    output i_key_n,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_hold
  );

  modport slave (
    input  i_key_n,
    output o_level,
    output o_press,
    output o_release,
    output o_hold
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-FF sync, per-key debounce, press/release/long-press pulses,
// with press pulses reduced to the highest-index key so stop always wins over start.
module key_conditioner #(
  parameter int N_KEYS       = 3,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int HOLD_CYC     = 12000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  key_conditioner_if.slave kif
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  logic [N_KEYS-1:0]             sync1_q, sync1_d;
  logic [N_KEYS-1:0]             sync2_q, sync2_d;
  logic [N_KEYS-1:0]             stable_q, stable_d;
  logic [N_KEYS-1:0]             stable_prev_q, stable_prev_d;
  logic [N_KEYS-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [N_KEYS-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_KEYS-1:0]             hold_done_q, hold_done_d;
  logic [N_KEYS-1:0]             press_q, press_d;
  logic [N_KEYS-1:0]             release_q, release_d;
  logic [N_KEYS-1:0]             hold_q, hold_d;

  // Keep only the highest-index request; lower ones are dropped, not queued.
  function automatic logic [N_KEYS-1:0] keep_highest(input logic [N_KEYS-1:0] req);
    logic [N_KEYS-1:0] sel;
    sel = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (req[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  always_comb begin
    sync1_d       = ~kif.i_key_n;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    hold_done_d   = hold_done_q;
    hold_d        = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (sync2_q[k] == stable_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DB_LAST) begin
        stable_d[k] = sync2_q[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
      end

      // hold_done freezes the counter so a long press fires exactly once
      if (!stable_q[k]) begin
        hold_cnt_d[k]  = '0;
        hold_done_d[k] = 1'b0;
      end else if (hold_done_q[k]) begin
        hold_cnt_d[k] = hold_cnt_q[k];
      end else if (hold_cnt_q[k] == HOLD_LAST) begin
        hold_d[k]      = 1'b1;
        hold_done_d[k] = 1'b1;
      end else begin
        hold_cnt_d[k] = hold_cnt_q[k] + HOLD_W'(1);
      end
    end
    press_d   = keep_highest(stable_q & ~stable_prev_q);
    release_d = ~stable_q & stable_prev_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      hold_done_q   <= '0;
      press_q       <= '0;
      release_q     <= '0;
      hold_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      hold_done_q   <= hold_done_d;
      press_q       <= press_d;
      release_q     <= release_d;
      hold_q        <= hold_d;
    end
  end

  assign kif.o_level   = stable_q;
  assign kif.o_press   = press_q;
  assign kif.o_release = release_q;
  assign kif.o_hold    = hold_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYC=4, HOLD_CYC=20, 3 keys.
// After tick number c following a key change, the DUT state is the one after edge k+c-1.
module tb_key_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  key_conditioner_if #(.N_KEYS(3)) kif ();

  key_conditioner #(
    .N_KEYS(3),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC(20)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .kif    (kif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    kif.i_key_n = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({kif.o_level, kif.o_press, kif.o_release, kif.o_hold} !== 12'h000) begin
      $display("FAIL reset_immediate got=%h exp=000",
               {kif.o_level, kif.o_press, kif.o_release, kif.o_hold});
      n_fail++;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      n_checks++;
      if ({kif.o_level, kif.o_press, kif.o_release, kif.o_hold} !== 12'h000) begin
        $display("FAIL reset_idle c=%0d got=%h exp=000", c,
                 {kif.o_level, kif.o_press, kif.o_release, kif.o_hold});
        n_fail++;
      end
    end
  endtask

  task automatic test_clean_press();
    kif.i_key_n = 3'b110;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (kif.o_level !== ((c >= 6) ? 3'b001 : 3'b000)) begin
        $display("FAIL clean_level c=%0d got=%b exp=%b", c, kif.o_level,
                 (c >= 6) ? 3'b001 : 3'b000);
        n_fail++;
      end
      n_checks++;
      if (kif.o_press !== ((c == 7) ? 3'b001 : 3'b000)) begin
        $display("FAIL clean_press c=%0d got=%b exp=%b", c, kif.o_press,
                 (c == 7) ? 3'b001 : 3'b000);
        n_fail++;
      end
    end
    repeat (20) tick();
    kif.i_key_n = 3'b111;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (kif.o_level !== ((c >= 6) ? 3'b000 : 3'b001)) begin
        $display("FAIL release_level c=%0d got=%b exp=%b", c, kif.o_level,
                 (c >= 6) ? 3'b000 : 3'b001);
        n_fail++;
      end
      n_checks++;
      if (kif.o_release !== ((c == 7) ? 3'b001 : 3'b000)) begin
        $display("FAIL clean_release c=%0d got=%b exp=%b", c, kif.o_release,
                 (c == 7) ? 3'b001 : 3'b000);
        n_fail++;
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    int presses;
    int releases;
    kif.i_key_n = 3'b101;
    repeat (3) tick();
    kif.i_key_n = 3'b111;
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_checks++;
      if ({kif.o_level, kif.o_press} !== 6'b000000) begin
        $display("FAIL glitch_short c=%0d got=%b exp=000000", c, {kif.o_level, kif.o_press});
        n_fail++;
      end
    end
    presses  = 0;
    releases = 0;
    kif.i_key_n = 3'b101;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c == 6) kif.i_key_n = 3'b111;
      if (kif.o_press == 3'b010) presses++;
      if (kif.o_release == 3'b010) releases++;
      n_checks++;
      if ((kif.o_press & 3'b101) !== 3'b000) begin
        $display("FAIL glitch_other_bits c=%0d got=%b exp=0x0", c, kif.o_press);
        n_fail++;
      end
    end
    n_checks++;
    if (presses != 1) begin
      $display("FAIL glitch_long_press count got=%0d exp=1", presses);
      n_fail++;
    end
    n_checks++;
    if (releases != 1) begin
      $display("FAIL glitch_long_release count got=%0d exp=1", releases);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    kif.i_key_n = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (kif.o_press !== ((c == 7) ? 3'b100 : 3'b000)) begin
        $display("FAIL simul_press c=%0d got=%b exp=%b", c, kif.o_press,
                 (c == 7) ? 3'b100 : 3'b000);
        n_fail++;
      end
    end
    n_checks++;
    if (kif.o_level !== 3'b101) begin
      $display("FAIL simul_level got=%b exp=101", kif.o_level);
      n_fail++;
    end
    kif.i_key_n = 3'b111;
    repeat (20) tick();
  endtask

  task automatic test_hold();
    kif.i_key_n = 3'b101;
    for (int c = 1; c <= 60; c++) begin
      tick();
      n_checks++;
      if (kif.o_hold !== ((c == 26) ? 3'b010 : 3'b000)) begin
        $display("FAIL hold_pulse c=%0d got=%b exp=%b", c, kif.o_hold,
                 (c == 26) ? 3'b010 : 3'b000);
        n_fail++;
      end
      if (c == 6) begin
        n_checks++;
        if (kif.o_level !== 3'b010) begin
          $display("FAIL hold_level got=%b exp=010", kif.o_level);
          n_fail++;
        end
      end
    end
    kif.i_key_n = 3'b111;
    repeat (20) tick();
    kif.i_key_n = 3'b101;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 15) kif.i_key_n = 3'b111;
      n_checks++;
      if (kif.o_hold !== 3'b000) begin
        $display("FAIL hold_short c=%0d got=%b exp=000", c, kif.o_hold);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    kif.i_key_n = 3'b011;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({kif.o_level, kif.o_press, kif.o_release, kif.o_hold} !== 12'h000) begin
      $display("FAIL midreset_outputs got=%h exp=000",
               {kif.o_level, kif.o_press, kif.o_release, kif.o_hold});
      n_fail++;
    end
    kif.i_key_n = 3'b111;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_checks++;
      if ({kif.o_level, kif.o_press} !== 6'b000000) begin
        $display("FAIL midreset_nopress c=%0d got=%b exp=000000", c, {kif.o_level, kif.o_press});
        n_fail++;
      end
    end
    kif.i_key_n = 3'b110;
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (kif.o_press !== ((c == 7) ? 3'b001 : 3'b000)) begin
        $display("FAIL held_through_reset c=%0d got=%b exp=%b", c, kif.o_press,
                 (c == 7) ? 3'b001 : 3'b000);
        n_fail++;
      end
    end
    kif.i_key_n = 3'b111;
    repeat (20) tick();
  endtask

  initial begin
    kif.i_key_n = 3'b111;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
